// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter (bin2bcd_seq) and its digit-adjust cell (bcd_add3).
//   state_t     : controller states IDLE / OP / DONE
//   BCD_DIGITS  : working BCD digits (5, enough for any 16-bit input)
//   OUT_DIGITS  : digits presented to the display multiplexer (4)
//   W_MAX       : widest supported input
//   BCD_MAX     : largest value the four output digits can show
//   CNT_W       : iteration counter width, sized to hold W_MAX
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 5;
  localparam int OUT_DIGITS = 4;
  localparam int W_MAX      = 16;
  localparam int BCD_MAX    = 9999;
  localparam int CNT_W      = $clog2(W_MAX + 1);

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: combinational double-dabble digit adjust.
// A digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit.
//   i_digit  in  4  working BCD digit
//   o_digit  out 4  adjusted digit
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3) that
// drives the four-digit seven-segment multiplexer. Output digits are
// registered and only change when a conversion completes, so the display
// never shows intermediate values.
//
// Optional feature macro: BIN2BCD_SAT_EN
//   defined   : values above 9999 show 9,9,9,9 and raise ovf
//   undefined : digits are the value mod 10000, ovf tied to 0
//
// Ports
//   clk        in  1  system clock, rising edge
//   reset      in  1  synchronous active-high reset
//   start      in  1  conversion request, sampled only while ready
//   bin        in  W  unsigned value, captured when start is accepted
//   ready      out 1  idle, can accept start
//   done_tick  out 1  one-cycle pulse, new digits valid this cycle
//   bcd3..bcd0 out 4  result digits, thousands down to units
//   ovf        out 1  captured value exceeded 9999 (saturating build only)
//
// state | meaning
// IDLE  | waiting for start, ready=1, outputs hold last result
// OP    | one shift/adjust iteration per cycle, W cycles total
// DONE  | one cycle, done_tick=1, new digits visible
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic         ovf
);

  localparam int              BCD_W = 4 * BCD_DIGITS;
  localparam int              OUT_W = 4 * OUT_DIGITS;
  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

  state_t             r_state;
  logic [W-1:0]       r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_done;
  logic [OUT_W-1:0]   r_dig;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_next_bcd;
  logic               w_unused_adj_msb;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The top adjusted bit falls off the end of the shift; five digits are
  // enough that it is never a real carry for inputs up to W_MAX bits.
  assign w_next_bcd       = {w_adj[BCD_W-2:0], r_shift[W-1]};
  assign w_unused_adj_msb = w_adj[BCD_W-1];

`ifdef BIN2BCD_SAT_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_dig   <= '0;
`ifdef BIN2BCD_SAT_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= OP;
            r_ready <= 1'b0;
            r_shift <= bin;
            r_bcd   <= '0;
            r_cnt   <= W_CNT;
          end
        end
        OP: begin
          r_shift <= r_shift << 1;
          r_bcd   <= w_next_bcd;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            // Last iteration: publish the finished result alongside DONE.
            r_state <= DONE;
            r_done  <= 1'b1;
`ifdef BIN2BCD_SAT_EN
            if (w_next_bcd[BCD_W-1:OUT_W] != '0) begin
              r_dig <= {OUT_DIGITS{4'd9}};
              r_ovf <= 1'b1;
            end else begin
              r_dig <= w_next_bcd[OUT_W-1:0];
              r_ovf <= 1'b0;
            end
`else
            r_dig   <= w_next_bcd[OUT_W-1:0];
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done_tick = r_done;
  assign bcd3      = r_dig[15:12];
  assign bcd2      = r_dig[11:8];
  assign bcd1      = r_dig[7:4];
  assign bcd0      = r_dig[3:0];

`ifdef BIN2BCD_SAT_EN
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        ready, done_tick, ovf;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;

  logic        start4;
  logic [3:0]  bin4;
  logic        ready4, done4, ovf4;
  logic [3:0]  d43, d42, d41, d40;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] prev_dig;
  logic        prev_ovf;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(14)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .ready(ready), .done_tick(done_tick),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .ovf(ovf)
  );

  bin2bcd_seq #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bin(bin4),
    .ready(ready4), .done_tick(done4),
    .bcd3(d43), .bcd2(d42), .bcd1(d41), .bcd0(d40), .ovf(ovf4)
  );

  // Reference: decimal digits by plain division, {ovf, d3, d2, d1, d0}.
  function automatic logic [16:0] model(input int v);
    int q;
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) return {1'b1, 16'h9999};
`endif
    q = v % 10000;
    return {1'b0, 4'(q / 1000), 4'((q / 100) % 10), 4'((q / 10) % 10), 4'(q % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full conversion on the W=14 instance. inj>0 drives a second start
  // (bin=7) during that OP cycle, which must be ignored.
  task automatic convert14(input int v, input int inj);
    logic [16:0] e;
    e = model(v);
    chk("ready_before", 32'(ready), 32'd1);
    bin   = 14'(v);
    start = 1'b1;
    step();
    start = 1'b0;
    bin   = 14'h3fff;
    for (int c = 1; c <= 14; c++) begin
      chk("op_ready", 32'(ready), 32'd0);
      chk("op_done", 32'(done_tick), 32'd0);
      chk("op_hold", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(prev_dig));
      if (c == inj) begin
        start = 1'b1;
        bin   = 14'd7;
      end
      step();
      start = 1'b0;
    end
    chk("done_tick", 32'(done_tick), 32'd1);
    chk("digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(e[15:0]));
    chk("ovf", 32'(ovf), 32'(e[16]));
    chk("done_ready", 32'(ready), 32'd0);
    prev_dig = e[15:0];
    prev_ovf = e[16];
    step();
    chk("ready_after", 32'(ready), 32'd1);
    chk("done_after", 32'(done_tick), 32'd0);
    chk("hold_after", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(prev_dig));
  endtask

  task automatic convert4(input int v);
    logic [16:0] e;
    e = model(v);
    bin4   = 4'(v);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("w4_op_done", 32'(done4), 32'd0);
      step();
    end
    chk("w4_done", 32'(done4), 32'd1);
    chk("w4_digits", 32'({d43, d42, d41, d40}), 32'(e[15:0]));
    chk("w4_ovf", 32'(ovf4), 32'd0);
    step();
    chk("w4_ready", 32'(ready4), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] e;
    int          v;
    int          seen;

    reset  = 1'b1;
    start  = 1'b0;
    bin    = '0;
    start4 = 1'b0;
    bin4   = '0;
    prev_dig = 16'h0;
    prev_ovf = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    step();

    convert14(1234, 0);
    convert14(0, 0);
    convert14(9999, 0);
    convert14(12345, 0);
    convert14(42, 5);

    // Abandon a conversion with reset.
    convert14(8888, 0);
    bin   = 14'd1111;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 6; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_done", 32'(done_tick), 32'd0);
    chk("rst_mid_digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'd0);
    prev_dig = 16'h0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_tick) seen++;
      step();
    end
    chk("rst_mid_no_done", 32'(seen), 32'd0);

    // Reset beats start.
    reset = 1'b1;
    start = 1'b1;
    bin   = 14'd5;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_ready", 32'(ready), 32'd1);
    step();
    chk("rst_start_idle", 32'(ready), 32'd1);

    // Start held high: back-to-back conversions every 16 cycles.
    bin   = 14'd321;
    start = 1'b1;
    step();
    bin   = 14'd654;
    for (int c = 1; c <= 14; c++) step();
    chk("b2b_done1", 32'(done_tick), 32'd1);
    chk("b2b_dig1", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h0321);
    step();
    chk("b2b_ready", 32'(ready), 32'd1);
    step();
    chk("b2b_busy", 32'(ready), 32'd0);
    for (int c = 17; c < 31; c++) step();
    chk("b2b_done2", 32'(done_tick), 32'd1);
    chk("b2b_dig2", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h0654);
    start = 1'b0;
    prev_dig = 16'h0654;
    prev_ovf = 1'b0;
    step();

    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(0, 16383));
      convert14(v, (k % 3 == 0) ? int'($urandom_range(1, 14)) : 0);
    end
    e = model(16383);
    convert14(16383, 0);
    chk("max_digits", 32'(prev_dig), 32'(e[15:0]));

    convert4(15);
    for (int k = 0; k < 4; k++) convert4(int'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter feeding the four-digit seven-segment multiplexer. It converts an unsigned binary value into four BCD digits using iterative shift-and-add-3 (double dabble). The digit outputs connect directly to the multiplexer's four hex digit inputs, with `bcd3` as the most significant digit. The outputs stay stable between conversions, so the display never shows intermediate working values.

## Interface
- `W`, default 14: input width in bits; legal range is 1..16.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start`  in  1  conversion request; sampled only while `ready` is 1.
- `bin`  in  W  unsigned value to convert; captured on the cycle `start` is accepted.
- `ready`  out  1  high in IDLE; the block can accept `start`.
- `done_tick`  out  1  one-cycle pulse; the new digits are valid from this cycle.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  out  4 each  result digits, thousands down to units.
- `ovf`  out  1  captured value exceeded 9999 (see Configuration).

## Operation
- States:
  - IDLE: `ready`=1. When `start`=1, go to OP.
  - OP: runs exactly W cycles, then goes to DONE.
  - DONE: lasts 1 cycle, then returns to IDLE.
- On accept:
  - Shift register ← `bin`.
  - Working BCD register ← 0. It is 5 digits (20 bits), so any 16-bit value converts exactly.
  - Iteration counter ← W.
- Each OP cycle:
  - Every working digit ≥ 5 gets +3.
  - The {working BCD, shift register} pair then shifts left 1; the shift MSB enters the units digit LSB.
  - The counter decrements. When the counter is 1 on this cycle, the next state is DONE.
- On the OP→DONE edge, the output registers load:
  - `bcd3..bcd0` ← working digits 3..0.
  - `ovf` ← (digit 4 ≠ 0), subject to Configuration.
- `done_tick` = (state == DONE).
- Outputs hold their last result through IDLE and OP. They change only on the OP→DONE edge.
- `start` while not IDLE: ignored and not queued. `bin` is ignored outside the accept cycle.
- `start` held high continuously: a new conversion is accepted on the first IDLE cycle after each DONE.

## Timing
- Reset values:
  - State = IDLE.
  - `ready`=1, `done_tick`=0.
  - `bcd3..bcd0`=0, `ovf`=0.
  - Working registers and counter = 0.
- Reset mid-conversion: the block returns to IDLE on the next edge. The conversion is abandoned and no `done_tick` is produced.
- `reset` and `start` in the same cycle: `reset` wins.
- Latency, with `start` accepted at edge 0:
  - OP occupies cycles 1..W.
  - `done_tick`=1 and new digits are valid in cycle W+1.
  - `ready` returns to 1 in cycle W+2.
  - For W=14: `done_tick` in cycle 15; throughput is one conversion per 16 cycles.
- `ready`=0 throughout OP and DONE.

## Configuration
- Macro: `BIN2BCD_SAT_EN`.
- Defined:
  - A captured value > 9999 drives `bcd3..bcd0` = 9,9,9,9 and `ovf`=1.
  - Otherwise the digits are the exact result and `ovf`=0.
- Undefined:
  - Digits are the value mod 10000, i.e. the low four working digits.
  - `ovf` is tied to 0.
  - The saturation logic is absent.
- Latency is identical in both builds.

## Structure
- Shared package `bin2bcd_pkg` contains:
  - State typedef with IDLE, OP, DONE.
  - `BCD_DIGITS`=5, `OUT_DIGITS`=4.
  - `W_MAX`=16.
  - `BCD_MAX`=9999.
- One sub-module, `bcd_add3`: a 4-bit combinational adjust (out = in ≥ 5 ? in+3 : in), instantiated once per working digit.
- The top level holds the FSM, the counter, the shift/working registers and the output registers.

## Test plan
- Directed scenarios (W=14):
  - `bin`=1234, pulse `start` → `done_tick` in cycle 15 with `bcd3..0`=1,2,3,4 and `ovf`=0; `ready` is 1 in cycle 16.
  - `bin`=0 → digits 0,0,0,0; `bin`=9999 → digits 9,9,9,9 with `ovf`=0.
  - `bin`=12345:
    - With `BIN2BCD_SAT_EN` → digits 9,9,9,9 and `ovf`=1.
    - Without it → digits 2,3,4,5 and `ovf`=0.
  - Start with `bin`=42; in cycle 5, `start` again with `bin`=7 → that request is ignored; the result is 0,0,4,2; outputs hold the previous digits during cycles 1..14.
  - Convert 8888, then start with 1111; assert `reset` in cycle 6 → IDLE next edge, digits 0,0,0,0, no `done_tick`, `ready`=1.
  - W=4, `bin`=15 → `done_tick` in cycle 5 with digits 0,0,1,5.
